// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the 2048 board draw scheduler: FSM encoding, colours
// and board geometry.
package draw_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_GRID  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_RED   = 3'b100;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    localparam int BOX_NIBBLE = 4;
    localparam int NUM_BOXES  = 16;
    localparam int BOARD_W    = BOX_NIBBLE * NUM_BOXES;
    localparam int COORD_W    = 7;
    localparam int COLOUR_W   = 3;

endpackage

// File: rtl/draw_scheduler_clear_sweeper.sv
// Raster counter for the background clear: x runs fastest, both wrap to 0
// after the last pixel so the next sweep starts at the origin.
module draw_scheduler_clear_sweeper
    import draw_scheduler_pkg::*;
#(
    parameter int X_MAX = 127,
    parameter int Y_MAX = 119
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               x_end;
    logic               y_end;

    assign x_end  = (x_q == COORD_W'(X_MAX));
    assign y_end  = (y_q == COORD_W'(Y_MAX));
    assign last_o = x_end && y_end;
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Owns the VGA pixel bus: sequences background clear and draw_grid passes
// over a shadow copy of the board, queueing requests that arrive while busy.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int               CLR_X_MAX   = 127,
    parameter int               CLR_Y_MAX   = 119,
    parameter logic [2:0]       CLR_COLOUR  = COLOUR_BLACK,
    parameter int               GRID_CYCLES = 3840
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [BOARD_W-1:0]  values_i,
    input  logic                board_update_i,
    input  logic                clear_req_i,
    input  logic [COORD_W-1:0]  grid_x_i,
    input  logic [COORD_W-1:0]  grid_y_i,
    input  logic [COLOUR_W-1:0] grid_colour_i,
    output logic [BOARD_W-1:0]  grid_values_o,
    output logic                grid_reset_o,
    output logic [COORD_W-1:0]  vga_x_o,
    output logic [COORD_W-1:0]  vga_y_o,
    output logic [COLOUR_W-1:0] vga_colour_o,
    output logic                plot_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_W = $clog2(GRID_CYCLES);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BOARD_W-1:0]  grid_values_q, grid_values_d;
    logic                pend_clr_q, pend_clr_d;
    logic                pend_grid_q, pend_grid_d;
    logic [COORD_W-1:0]  clr_x;
    logic [COORD_W-1:0]  clr_y;
    logic                clr_last;
    logic                plot_c;

    draw_scheduler_clear_sweeper #(
        .X_MAX (CLR_X_MAX),
        .Y_MAX (CLR_Y_MAX)
    ) u_sweeper (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .en_i    (state_q == ST_CLEAR),
        .x_o     (clr_x),
        .y_o     (clr_y),
        .last_o  (clr_last)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req_i || pend_clr_q) begin
                    state_d = ST_CLEAR;
                end else if (board_update_i || pend_grid_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_CLEAR: if (clr_last) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_GRID;
            ST_GRID:  if (cnt_q == CNT_W'(GRID_CYCLES - 1)) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Any request seen in IDLE starts a sequence that serves every request
    // outstanding at that moment, so both flags drop there.
    always_comb begin
        pend_clr_d    = pend_clr_q;
        pend_grid_d   = pend_grid_q;
        cnt_d         = cnt_q;
        grid_values_d = grid_values_q;
        if (state_q == ST_IDLE) begin
            pend_clr_d  = 1'b0;
            pend_grid_d = 1'b0;
        end else begin
            pend_clr_d  = pend_clr_q  | clear_req_i;
            pend_grid_d = pend_grid_q | board_update_i;
        end
        if (state_q == ST_LOAD) begin
            cnt_d         = '0;
            grid_values_d = values_i;
        end else if (state_q == ST_GRID) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q         <= '0;
            grid_values_q <= '0;
            pend_clr_q    <= 1'b0;
            pend_grid_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            grid_values_q <= grid_values_d;
            pend_clr_q    <= pend_clr_d;
            pend_grid_q   <= pend_grid_d;
        end
    end

    always_comb begin
        plot_c       = 1'b0;
        grid_reset_o = 1'b1;
        vga_x_o      = '0;
        vga_y_o      = '0;
        vga_colour_o = '0;
        done_o       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                plot_c       = 1'b1;
                vga_x_o      = clr_x;
                vga_y_o      = clr_y;
                vga_colour_o = CLR_COLOUR;
            end
            ST_GRID: begin
                plot_c       = 1'b1;
                grid_reset_o = 1'b0;
                vga_x_o      = grid_x_i;
                vga_y_o      = grid_y_i;
                vga_colour_o = grid_colour_i;
            end
            ST_FIN:  done_o = 1'b1;
            default: ;
        endcase
    end

    // The reset state is CLEAR, but the VGA bus must stay quiet while reset is held.
    assign plot_o        = plot_c & ~reset_i;
    assign busy_o        = (state_q != ST_IDLE);
    assign grid_values_o = grid_values_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus queues expected pixels and
// done snapshots, a negedge monitor pops and compares them.
module tb_draw_scheduler;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [63:0] values_i = 64'h0;
    logic        board_update_i = 1'b0;
    logic        clear_req_i = 1'b0;
    logic [6:0]  grid_x_i;
    logic [6:0]  grid_y_i;
    logic [2:0]  grid_colour_i;
    logic [63:0] grid_values_o;
    logic        grid_reset_o;
    logic [6:0]  vga_x_o;
    logic [6:0]  vga_y_o;
    logic [2:0]  vga_colour_o;
    logic        plot_o;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;
    int glow  = 0;

    logic [16:0] pixq[$];
    logic [63:0] doneq[$];
    logic [11:0] k;

    draw_scheduler dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .values_i       (values_i),
        .board_update_i (board_update_i),
        .clear_req_i    (clear_req_i),
        .grid_x_i       (grid_x_i),
        .grid_y_i       (grid_y_i),
        .grid_colour_i  (grid_colour_i),
        .grid_values_o  (grid_values_o),
        .grid_reset_o   (grid_reset_o),
        .vga_x_o        (vga_x_o),
        .vga_y_o        (vga_y_o),
        .vga_colour_o   (vga_colour_o),
        .plot_o         (plot_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clock_i = ~clock_i;

    // Stand-in for draw_grid: a pixel counter held at 0 while in reset.
    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i || grid_reset_o) k <= '0;
        else                         k <= k + 12'd1;
    end
    assign grid_x_i      = k[6:0];
    assign grid_y_i      = k[10:4];
    assign grid_colour_i = k[2:0] ^ k[5:3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] grid_px(input int j);
        logic [11:0] v;
        v = 12'(j);
        return {v[6:0], v[10:4], v[2:0] ^ v[5:3]};
    endfunction

    task automatic push_clear();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 128; x++)
                pixq.push_back({7'(x), 7'(y), 3'b000});
    endtask

    task automatic push_grid(input logic [63:0] v);
        for (int j = 0; j < 3840; j++) pixq.push_back(grid_px(j));
        doneq.push_back(v);
    endtask

    // Completion means busy low on two consecutive samples: a queued pass
    // leaves exactly one IDLE cycle between FIN and LOAD.
    task automatic wait_done(input string nm, input int max);
        int lowrun;
        int n;
        lowrun = 0;
        n = 0;
        repeat (3) @(negedge clock_i);
        while (lowrun < 2 && n < max) begin
            @(negedge clock_i);
            n++;
            if (!busy_o) lowrun++;
            else         lowrun = 0;
        end
        if (n >= max) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles", nm, n);
        end
        chk({nm, "_pix_left"}, 64'(pixq.size()), 64'd0);
        chk({nm, "_done_left"}, 64'(doneq.size()), 64'd0);
    endtask

    always @(negedge clock_i) begin
        if (!grid_reset_o) glow++;
        if (plot_o) begin
            if (pixq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_plot: got (%0d,%0d,%0d) expected no plot",
                         vga_x_o, vga_y_o, vga_colour_o);
            end else begin
                chk("pixel", {47'd0, vga_x_o, vga_y_o, vga_colour_o}, {47'd0, pixq.pop_front()});
            end
            if (!grid_reset_o)
                chk("vga_mirror", {47'd0, vga_x_o, vga_y_o, vga_colour_o},
                    {47'd0, grid_x_i, grid_y_i, grid_colour_i});
        end
        if (done_o) begin
            if (doneq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                chk("done_grid_values", grid_values_o, doneq.pop_front());
            end
        end
    end

    initial begin
        int n;
        // 1: reset values, then power-up clear + grid pass
        values_i = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("rst_plot", 64'(plot_o), 64'd0);
        chk("rst_grid_reset", 64'(grid_reset_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_vga", {47'd0, vga_x_o, vga_y_o, vga_colour_o}, 64'd0);
        chk("rst_grid_values", grid_values_o, 64'd0);
        push_clear();
        push_grid(64'h0123_4567_89AB_CDEF);
        @(negedge clock_i);
        reset_i = 1'b0;
        wait_done("t1", 25000);

        // 2: single board_update from IDLE
        values_i = 64'h1000_0000_0000_0002;
        glow = 0;
        push_grid(64'h1000_0000_0000_0002);
        board_update_i = 1'b1;
        @(negedge clock_i);
        board_update_i = 1'b0;
        chk("t2_load_plot", 64'(plot_o), 64'd0);
        chk("t2_load_busy", 64'(busy_o), 64'd1);
        @(negedge clock_i);
        chk("t2_grid_plot", 64'(plot_o), 64'd1);
        wait_done("t2", 6000);
        chk("t2_grid_low_cycles", 64'(glow), 64'd3840);

        // 3: three updates during GRID collapse into one extra pass
        values_i = 64'hAAAA_BBBB_CCCC_DDDD;
        push_grid(64'hAAAA_BBBB_CCCC_DDDD);
        push_grid(64'h2222_0000_4444_0008);
        board_update_i = 1'b1;
        @(negedge clock_i);
        board_update_i = 1'b0;
        repeat (100) @(negedge clock_i);
        values_i = 64'h2222_0000_4444_0008;
        for (int p = 0; p < 3; p++) begin
            board_update_i = 1'b1;
            @(negedge clock_i);
            board_update_i = 1'b0;
            repeat (700) @(negedge clock_i);
        end
        chk("t3_shadow_stable", grid_values_o, 64'hAAAA_BBBB_CCCC_DDDD);
        wait_done("t3", 12000);

        // 4: clear_req and board_update together
        values_i = 64'h0000_1111_2222_3333;
        push_clear();
        push_grid(64'h0000_1111_2222_3333);
        clear_req_i = 1'b1;
        board_update_i = 1'b1;
        @(negedge clock_i);
        clear_req_i = 1'b0;
        board_update_i = 1'b0;
        wait_done("t4", 25000);
        n = 0;
        repeat (10) begin
            @(negedge clock_i);
            if (busy_o) n++;
        end
        chk("t4_no_pending_busy", 64'(n), 64'd0);

        // 5: reset at GRID cnt=1000
        values_i = 64'h5555_6666_7777_8888;
        push_grid(64'h5555_6666_7777_8888);
        board_update_i = 1'b1;
        @(negedge clock_i);
        board_update_i = 1'b0;
        n = 0;
        while (grid_reset_o && n < 10) begin
            @(negedge clock_i);
            n++;
        end
        repeat (1000) @(negedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        pixq.delete();
        doneq.delete();
        chk("t5_rst_plot", 64'(plot_o), 64'd0);
        chk("t5_rst_grid_reset", 64'(grid_reset_o), 64'd1);
        chk("t5_rst_done", 64'(done_o), 64'd0);
        chk("t5_rst_vga", {47'd0, vga_x_o, vga_y_o, vga_colour_o}, 64'd0);
        chk("t5_rst_grid_values", grid_values_o, 64'd0);
        push_clear();
        push_grid(64'h5555_6666_7777_8888);
        @(negedge clock_i);
        reset_i = 1'b0;
        wait_done("t5", 25000);

        // 6: board_update coincident with FIN
        values_i = 64'h9999_0000_0000_0001;
        push_grid(64'h9999_0000_0000_0001);
        board_update_i = 1'b1;
        @(negedge clock_i);
        board_update_i = 1'b0;
        n = 0;
        while (!done_o && n < 5000) begin
            @(negedge clock_i);
            n++;
        end
        chk("t6_saw_fin", 64'(done_o), 64'd1);
        values_i = 64'hFEDC_BA98_7654_3210;
        push_grid(64'hFEDC_BA98_7654_3210);
        board_update_i = 1'b1;
        @(negedge clock_i);
        board_update_i = 1'b0;
        chk("t6_idle_busy", 64'(busy_o), 64'd0);
        chk("t6_idle_done", 64'(done_o), 64'd0);
        @(negedge clock_i);
        chk("t6_load_busy", 64'(busy_o), 64'd1);
        chk("t6_load_plot", 64'(plot_o), 64'd0);
        chk("t6_load_grid_reset", 64'(grid_reset_o), 64'd1);
        @(negedge clock_i);
        chk("t6_grid_reset_low", 64'(grid_reset_o), 64'd0);
        wait_done("t6", 6000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
